// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character FIFO with per-entry status tags.
// Tracks fill level, any stored error and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int fifo_width     = 11,
  parameter int fifo_depth     = 16,
  parameter int fifo_pointer_w = 4,
  parameter int fifo_counter_w = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [fifo_width-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  output logic [fifo_width-1:0]     data_out,
  output logic [fifo_counter_w-1:0] count,
  output logic                      error_bit,
  output logic                      overrun
);

  localparam logic [fifo_counter_w-1:0] depth_c =
    fifo_counter_w'(fifo_depth);

  logic [fifo_width-1:0]     mem [fifo_depth];
  logic [fifo_depth-1:0]     err_flag;
  logic [fifo_pointer_w-1:0] rd_ptr;
  logic [fifo_pointer_w-1:0] wr_ptr;
  logic                      full;
  logic                      empty;
  logic                      wr_en;
  logic                      rd_en;
  logic                      ovr_set;

  assign full    = (count == depth_c);
  assign empty   = (count == '0);
  // A full FIFO still takes a write when the head leaves the same cycle.
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign ovr_set = push && !pop && full;

  assign data_out  = mem[rd_ptr];
  assign error_bit = |err_flag;

  // Storage and per-entry error flags; a write wins over the pop clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem[i] <= '0;
      end
      err_flag <= '0;
    end else begin
      if (rd_en) begin
        err_flag[rd_ptr] <= 1'b0;
      end
      if (wr_en) begin
        mem[wr_ptr]      <= data_in;
        err_flag[wr_ptr] <= |data_in[2:0];
      end
    end
  end

  // Pointers wrap naturally; count tracks the net change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun, released by the next accepted pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (rd_en) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo.
// Queue model holds expected entries; heads are checked on each pop.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] data_in = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [10:0] data_out;
  logic [4:0]  count;
  logic        error_bit;
  logic        overrun;

  int n_run  = 0;
  int n_fail = 0;

  logic [10:0] sb [$];
  logic        m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .push      (push),
    .pop       (pop),
    .data_out  (data_out),
    .count     (count),
    .error_bit (error_bit),
    .overrun   (overrun)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_err();
    logic e = 1'b0;
    foreach (sb[i]) e |= |sb[i][2:0];
    return e;
  endfunction

  task automatic op(input logic p, input logic q,
                    input logic [10:0] d);
    bit full, emp, wr, rd;
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    #1;
    emp = (sb.size() == 0);
    full = (sb.size() == 16);
    wr = p && (!full || q);
    rd = q && !emp;
    if (rd) check("head", {21'd0, data_out}, {21'd0, sb[0]});
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    if (rd) void'(sb.pop_front());
    if (wr) sb.push_back(d);
    if (p && !q && full) m_ovr = 1'b1;
    else if (rd) m_ovr = 1'b0;
    check("count", {27'd0, count}, sb.size());
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("error_bit", {31'd0, error_bit}, {31'd0, m_err()});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    data_in = 11'h7FF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    sb.delete();
    m_ovr = 1'b0;
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_error", {31'd0, error_bit}, 32'd0);
    check("rst_data", {21'd0, data_out}, 32'd0);
  endtask

  initial begin
    do_reset();

    op(1, 0, 11'h7F8);
    check("first_data", {21'd0, data_out}, 32'h7F8);
    check("first_count", {27'd0, count}, 32'd1);
    op(0, 1, '0);

    op(1, 0, 11'h008);
    op(1, 0, 11'h010);
    op(1, 0, 11'h018);
    check("three_count", {27'd0, count}, 32'd3);
    for (int i = 0; i < 4; i++) op(0, 1, '0);
    check("empty_pop", {27'd0, count}, 32'd0);

    for (int i = 0; i < 16; i++) op(1, 0, 11'((i + 1) << 3));
    op(1, 0, 11'h7F8);
    check("full_count", {27'd0, count}, 32'd16);
    check("full_ovr", {31'd0, overrun}, 32'd1);
    check("full_head", {21'd0, data_out}, 32'h008);
    op(0, 1, '0);
    check("ovr_clear", {31'd0, overrun}, 32'd0);
    op(1, 0, 11'h3F0);
    op(1, 1, 11'h2A8);
    check("pp_full_cnt", {27'd0, count}, 32'd16);
    check("pp_full_ovr", {31'd0, overrun}, 32'd0);
    check("pp_full_head", {21'd0, data_out}, 32'h018);
    while (sb.size() > 0) op(0, 1, '0);
    op(1, 1, 11'h150);
    check("pp_empty_cnt", {27'd0, count}, 32'd1);
    check("pp_empty_data", {21'd0, data_out}, 32'h150);
    op(0, 1, '0);

    op(1, 0, 11'h020);
    op(1, 0, 11'h001);
    op(1, 0, 11'h028);
    check("err_set", {31'd0, error_bit}, 32'd1);
    op(0, 1, '0);
    check("err_held", {31'd0, error_bit}, 32'd1);
    op(0, 1, '0);
    check("err_gone", {31'd0, error_bit}, 32'd0);
    op(0, 1, '0);

    for (int i = 0; i < 300; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
         11'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      op(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
         11'($urandom));
    end

    while (sb.size() < 16) op(1, 0, 11'h0C4);
    op(1, 0, 11'h0C9);
    check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
    check("pre_rst_err", {31'd0, error_bit}, 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
